// File: rtl/aes_pkg.sv
// Shared AES definitions: key-length encodings, Nk/Nr lookup, GF(2^8) xtime and the forward S-box table.
package aes_pkg;

  typedef enum logic [1:0] {
    KEY_128  = 2'b00,
    KEY_192  = 2'b01,
    KEY_256  = 2'b10,
    KEY_RSVD = 2'b11
  } key_len_e;

  // Forward S-box, entry 0 in the top byte.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [3:0] nk_of(input key_len_e len);
    case (len)
      KEY_128: return 4'd4;
      KEY_192: return 4'd6;
      default: return 4'd8;
    endcase
  endfunction

  function automatic logic [3:0] nr_of(input key_len_e len);
    case (len)
      KEY_128: return 4'd10;
      KEY_192: return 4'd12;
      default: return 4'd14;
    endcase
  endfunction

  function automatic int key_bits_of(input key_len_e len);
    return 128 + 64 * int'(len);
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX_TABLE[(255 - int'(x)) * 8 +: 8];
  endfunction

endpackage

// File: rtl/aes_key_expand_if.sv
// Request and round-key stream bundle between a key-schedule client and aes_key_expand.
interface aes_key_expand_if #(
  parameter int MAX_KEY_BITS = 256,
  parameter int RK_INDEX_W   = 4
);
  logic                    enable;
  logic [MAX_KEY_BITS-1:0] keyIn;
  logic [1:0]              keyLen;
  logic                    startKey;
  logic                    abort;
  logic                    busy;
  logic                    rkValid;
  logic                    rkReady;
  logic [127:0]            rkData;
  logic [RK_INDEX_W-1:0]   rkIndex;
  logic                    rkLast;
  logic                    keyErr;

  modport master (
    output enable, keyIn, keyLen, startKey, abort, rkReady,
    input  busy, rkValid, rkData, rkIndex, rkLast, keyErr
  );

  modport slave (
    input  enable, keyIn, keyLen, startKey, abort, rkReady,
    output busy, rkValid, rkData, rkIndex, rkLast, keyErr
  );
endinterface

// File: rtl/aes_key_expand_sbox.sv
// SubWord: four parallel byte S-box lookups on a 32-bit word, purely combinational.
module aesSBoxWord
  import aes_pkg::*;
(
  input  logic [31:0] i_word,
  output logic [31:0] o_word
);
  for (genvar b = 0; b < 4; b++) begin : g_byte
    assign o_word[b*8 +: 8] = sbox(i_word[b*8 +: 8]);
  end
endmodule

// File: rtl/aes_key_expand.sv
// AES key schedule: produces one expansion word per enabled cycle, packs four words into a
// staging register and hands round keys out through a valid/ready output register.
module aes_key_expand
  import aes_pkg::*;
#(
  parameter int MAX_KEY_BITS = 256,
  parameter int RK_INDEX_W   = 4
) (
  input logic             pClk,
  input logic             sRst,
  aes_key_expand_if.slave bus
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_EXPAND = 2'd1;
  localparam logic [1:0] S_DRAIN  = 2'd2;

  logic [1:0]              r_state;
  logic [MAX_KEY_BITS-1:0] r_key;
  logic [31:0]             r_win [8];
  logic [7:0]              r_rcon;
  logic [3:0]              r_nk;
  logic [3:0]              r_nr;
  logic [5:0]              r_last_word;
  logic [5:0]              r_word_cnt;
  logic [2:0]              r_mod;
  logic [127:0]            r_stage_data;
  logic                    r_stage_valid;
  logic [RK_INDEX_W-1:0]   r_stage_idx;
  logic                    r_out_valid;
  logic [127:0]            r_out_data;
  logic [RK_INDEX_W-1:0]   r_out_idx;
  logic                    r_out_last;
  logic                    r_key_err;

  key_len_e    w_len;
  logic        w_len_ok;
  logic        w_req;
  logic        w_accept;
  logic        w_move;
  logic        w_gen;
  logic        w_in_key;
  logic [31:0] w_prev;
  logic [31:0] w_back;
  logic [31:0] w_sbox_in;
  logic [31:0] w_sbox_out;
  logic [31:0] w_temp;
  logic [31:0] w_word;
  logic [1:0]  w_lane;

  assign w_len    = key_len_e'(bus.keyLen);
  assign w_len_ok = (w_len != KEY_RSVD) && (key_bits_of(w_len) <= MAX_KEY_BITS);
  assign w_req    = bus.startKey && !bus.abort && (r_state == S_IDLE);
  assign w_accept = r_out_valid && bus.rkReady;
  assign w_move   = r_stage_valid && (!r_out_valid || w_accept);
  // A full staging register that cannot drain this cycle stalls generation.
  assign w_gen    = (r_state == S_EXPAND) && (!r_stage_valid || w_move);
  assign w_in_key = r_word_cnt < {2'b00, r_nk};
  assign w_lane   = r_word_cnt[1:0];

  assign w_prev    = r_win[0];
  assign w_back    = r_win[3'(r_nk - 4'd1)];
  assign w_sbox_in = (r_mod == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;

  aesSBoxWord u_sbox (
    .i_word (w_sbox_in),
    .o_word (w_sbox_out)
  );

  // NOTE: default assignment first so every path drives w_temp and no latch is inferred.
  always_comb begin
    w_temp = w_prev;
    if (r_mod == 3'd0)                         w_temp = w_sbox_out ^ {r_rcon, 24'h0};
    else if (r_nk == 4'd8 && r_mod == 3'd4)    w_temp = w_sbox_out;
  end

  assign w_word = w_in_key ? r_key[MAX_KEY_BITS-1 -: 32] : (w_back ^ w_temp);

  always_ff @(posedge pClk) begin
    if (sRst) begin
      r_state       <= S_IDLE;
      r_key         <= '0;
      r_rcon        <= 8'h00;
      r_nk          <= 4'd4;
      r_nr          <= 4'd10;
      r_last_word   <= 6'd0;
      r_word_cnt    <= 6'd0;
      r_mod         <= 3'd0;
      r_stage_data  <= '0;
      r_stage_valid <= 1'b0;
      r_stage_idx   <= '0;
      r_out_valid   <= 1'b0;
      r_out_data    <= '0;
      r_out_idx     <= '0;
      r_out_last    <= 1'b0;
      r_key_err     <= 1'b0;
      // NOTE: the word window is reset on purpose so it reads as cleared after sRst.
      for (int k = 0; k < 8; k++) r_win[k] <= '0;
    end else if (bus.enable) begin
      // NOTE: non-blocking assignments throughout so every register sees pre-edge values.
      r_key_err <= w_req && !w_len_ok;
      if (bus.abort) begin
        r_state       <= S_IDLE;
        r_stage_valid <= 1'b0;
        r_out_valid   <= 1'b0;
        r_out_last    <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: if (w_req && w_len_ok) begin
            r_state     <= S_EXPAND;
            r_key       <= bus.keyIn;
            r_nk        <= nk_of(w_len);
            r_nr        <= nr_of(w_len);
            r_last_word <= {nr_of(w_len), 2'b11};
            r_rcon      <= 8'h01;
            r_word_cnt  <= 6'd0;
            r_mod       <= 3'd0;
          end
          S_EXPAND: if (w_gen && r_word_cnt == r_last_word) r_state <= S_DRAIN;
          S_DRAIN:  if (w_accept && r_out_last) r_state <= S_IDLE;
          default:  r_state <= S_IDLE;
        endcase

        if (w_gen) begin
          r_win[0] <= w_word;
          for (int k = 1; k < 8; k++) r_win[k] <= r_win[k-1];
          r_word_cnt <= r_word_cnt + 6'd1;
          r_mod      <= (r_mod == 3'(r_nk - 4'd1)) ? 3'd0 : r_mod + 3'd1;
          if (w_in_key)            r_key  <= r_key << 32;
          else if (r_mod == 3'd0)  r_rcon <= xtime(r_rcon);
          r_stage_data[(3 - int'(w_lane)) * 32 +: 32] <= w_word;
        end

        if (w_move) r_stage_valid <= 1'b0;
        if (w_gen && w_lane == 2'd3) begin
          r_stage_valid <= 1'b1;
          r_stage_idx   <= RK_INDEX_W'(r_word_cnt[5:2]);
        end

        if (w_move) begin
          r_out_valid <= 1'b1;
          r_out_data  <= r_stage_data;
          r_out_idx   <= r_stage_idx;
          r_out_last  <= (r_stage_idx == RK_INDEX_W'(r_nr));
        end else if (w_accept) begin
          r_out_valid <= 1'b0;
          r_out_last  <= 1'b0;
        end
      end
    end
  end

  assign bus.busy    = (r_state != S_IDLE);
  assign bus.rkValid = r_out_valid;
  assign bus.rkData  = r_out_data;
  assign bus.rkIndex = r_out_idx;
  assign bus.rkLast  = r_out_last;
  assign bus.keyErr  = r_key_err;

endmodule
